// File: rtl/sbus_axi_bridge_pkg.sv
// Shared types and constants for the sbus-to-AXI3 bridge.
// Holds the FSM state encoding, AXI burst/cache codes and default IDs.
package sbus_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_R,
        WR_A,
        WR_B,
        DONE
    } state_e;

    localparam logic [1:0] INCR      = 2'b01;
    localparam logic [3:0] CACHE_UC  = 4'b0000;
    localparam logic [3:0] CACHE_WB  = 4'b1111;
    localparam logic [3:0] ID_I_DEF  = 4'd0;
    localparam logic [3:0] ID_D_DEF  = 4'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/sbus_axi_bridge_if.sv
// AXI3 single-port bundle between the bridge (master) and memory/interconnect (slave).
// Plain signal bundle; handshakes are standard AXI valid/ready.
interface sbus_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sbus_axi_bridge.sv
// Merges ibus/dbus single-word sbus requests onto one AXI3 master; dbus has priority.
// Latency: >=4 cycles per transfer (IDLE, addr, resp, DONE); SBUS_AXI_POSTED_WR_EN releases writes before B.
// Backpressure: each bus stalls (en & ~done) until its transfer completes; AXI channels wait on ready.
module sbus_axi_bridge
    import sbus_axi_bridge_pkg::*;
#(
    parameter logic [3:0] ID_I = ID_I_DEF,
    parameter logic [3:0] ID_D = ID_D_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ibus_en,
    input  logic [31:0]         ibus_addr,
    output logic [31:0]         ibus_rdata,
    output logic                ibus_stall,
    input  logic                dbus_en,
    input  logic [3:0]          dbus_wen,
    input  logic [1:0]          dbus_size,
    input  logic [31:0]         dbus_addr,
    input  logic [31:0]         dbus_wdata,
    output logic [31:0]         dbus_rdata,
    output logic                dbus_stall,
    input  logic                no_dcache,
    sbus_axi_bridge_if.master   axi
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;      // 1 = dbus owns the current transfer
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic        uc_q, uc_d;
    logic        aw_ok_q, aw_ok_d;
    logic        w_ok_q, w_ok_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        uc_d      = uc_q;
        aw_ok_d   = aw_ok_q;
        w_ok_d    = w_ok_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                aw_ok_d = 1'b0;
                w_ok_d  = 1'b0;
                if (dbus_en) begin
                    owner_d = 1'b1;
                    addr_d  = dbus_addr;
                    size_d  = dbus_size;
                    wen_d   = dbus_wen;
                    wdata_d = dbus_wdata;
                    uc_d    = no_dcache;
                    state_d = (dbus_wen != 4'b0000) ? WR_A : RD_A;
                end else if (ibus_en) begin
                    owner_d = 1'b0;
                    addr_d  = ibus_addr;
                    size_d  = SIZE_WORD[1:0];
                    wen_d   = 4'b0000;
                    uc_d    = 1'b0;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                if (axi.arready) state_d = RD_R;
            end
            RD_R: begin
                if (axi.rvalid && axi.rlast) begin
                    if (owner_q) begin
                        d_rdata_d = axi.rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = axi.rdata;
                        i_done_d  = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            WR_A: begin
                // AW and W are tracked separately so either may be accepted first.
                aw_ok_d = aw_ok_q | axi.awready;
                w_ok_d  = w_ok_q | axi.wready;
                if (aw_ok_d && w_ok_d) begin
                    state_d = WR_B;
`ifdef SBUS_AXI_POSTED_WR_EN
                    d_done_d = 1'b1;
`endif
                end
            end
            WR_B: begin
                if (axi.bvalid) begin
                    state_d = DONE;
`ifdef SBUS_AXI_POSTED_WR_EN
                    d_done_d = 1'b0;
`else
                    d_done_d = 1'b1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wen_q     <= '0;
            wdata_q   <= '0;
            uc_q      <= 1'b0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            uc_q      <= uc_d;
            aw_ok_q   <= aw_ok_d;
            w_ok_q    <= w_ok_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    logic [3:0] cache;
    assign cache = (owner_q && uc_q) ? CACHE_UC : CACHE_WB;

    assign axi.arvalid = (state_q == RD_A);
    assign axi.araddr  = addr_q;
    assign axi.arid    = owner_q ? ID_D : ID_I;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = INCR;
    assign axi.arcache = cache;
    assign axi.rready  = (state_q == RD_R);

    assign axi.awvalid = (state_q == WR_A) && !aw_ok_q;
    assign axi.awaddr  = addr_q;
    assign axi.awid    = ID_D;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = SIZE_WORD;
    assign axi.awburst = INCR;
    assign axi.awcache = cache;
    assign axi.wvalid  = (state_q == WR_A) && !w_ok_q;
    assign axi.wid     = ID_D;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wen_q;
    assign axi.wlast   = 1'b1;
    assign axi.bready  = (state_q == WR_B);

    assign ibus_stall = ibus_en & ~i_done_q;
    assign dbus_stall = dbus_en & ~d_done_q;
    assign ibus_rdata = i_rdata_q;
    assign dbus_rdata = d_rdata_q;

    // Single outstanding transfer, so response IDs and status carry no information here.
    logic unused_resp;
    assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sbus_axi_bridge.sv
// Directed bench for sbus_axi_bridge acting as the AXI slave; honours SBUS_AXI_POSTED_WR_EN.
module tb_sbus_axi_bridge;
    import sbus_axi_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_en;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_stall;
    logic        dbus_en;
    logic [3:0]  dbus_wen;
    logic [1:0]  dbus_size;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_stall;
    logic        no_dcache;

    int n_pass = 0;
    int n_chk  = 0;

    sbus_axi_bridge_if axi();

    sbus_axi_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_en    (ibus_en),
        .ibus_addr  (ibus_addr),
        .ibus_rdata (ibus_rdata),
        .ibus_stall (ibus_stall),
        .dbus_en    (dbus_en),
        .dbus_wen   (dbus_wen),
        .dbus_size  (dbus_size),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_stall (dbus_stall),
        .no_dcache  (no_dcache),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_accept(input string tag, input logic [31:0] addr, input logic [3:0] id,
                             input logic [2:0] size, input logic [3:0] cache);
        int n = 0;
        while (axi.arvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_arvalid"}, 32'(axi.arvalid), 32'd1);
        chk({tag, "_araddr"},  axi.araddr, addr);
        chk({tag, "_arid"},    32'(axi.arid), 32'(id));
        chk({tag, "_arsize"},  32'(axi.arsize), 32'(size));
        chk({tag, "_arcache"}, 32'(axi.arcache), 32'(cache));
        chk({tag, "_arlen"},   32'(axi.arlen), 32'd0);
        chk({tag, "_arburst"}, 32'(axi.arburst), 32'd1);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
    endtask

    task automatic r_return(input string tag, input logic [31:0] data, input logic [3:0] id);
        int n = 0;
        while (axi.rready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rready"}, 32'(axi.rready), 32'd1);
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b1;
        axi.rdata  = data;
        axi.rid    = id;
        axi.rresp  = 2'b00;
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ibus_en = 1'b0; ibus_addr = '0;
        dbus_en = 1'b0; dbus_wen = '0; dbus_size = '0; dbus_addr = '0; dbus_wdata = '0;
        no_dcache = 1'b0;
        axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
        axi.rlast = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;

        // Reset state
        #12;
        chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
        chk("rst_rready",  32'(axi.rready), 32'd0);
        chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
        chk("rst_wvalid",  32'(axi.wvalid), 32'd0);
        chk("rst_bready",  32'(axi.bready), 32'd0);
        chk("rst_irdata",  ibus_rdata, 32'h0);
        chk("rst_drdata",  dbus_rdata, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // T1: single ibus fetch, arready delayed two cycles
        ibus_en = 1'b1; ibus_addr = 32'hBFC0_0000;
        #1;
        chk("t1_stall_req", 32'(ibus_stall), 32'd1);
        tick();
        chk("t1_arvalid_c1", 32'(axi.arvalid), 32'd1);
        tick();
        chk("t1_arvalid_c2", 32'(axi.arvalid), 32'd1);
        ar_accept("t1", 32'hBFC0_0000, 4'd0, 3'd2, 4'b1111);
        chk("t1_arvalid_off", 32'(axi.arvalid), 32'd0);
        chk("t1_stall_rr",    32'(ibus_stall), 32'd1);
        r_return("t1", 32'h3C08_0001, 4'd0);
        chk("t1_stall_low", 32'(ibus_stall), 32'd0);
        chk("t1_rdata",     ibus_rdata, 32'h3C08_0001);
        tick();
        chk("t1_stall_back", 32'(ibus_stall), 32'd1);
        chk("t1_idle_ar",    32'(axi.arvalid), 32'd0);
        ibus_en = 1'b0;
        tick();

        // T2: simultaneous ibus fetch and dbus byte read; dbus goes first
        ibus_en = 1'b1; ibus_addr = 32'hBFC0_0004;
        dbus_en = 1'b1; dbus_wen = 4'b0000; dbus_size = 2'd0; dbus_addr = 32'h0000_1004;
        tick();
        ar_accept("t2d", 32'h0000_1004, 4'd1, 3'd0, 4'b1111);
        chk("t2_istall_a", 32'(ibus_stall), 32'd1);
        r_return("t2d", 32'h1122_3344, 4'd1);
        chk("t2_dstall_low", 32'(dbus_stall), 32'd0);
        chk("t2_drdata",     dbus_rdata, 32'h1122_3344);
        chk("t2_istall_b",   32'(ibus_stall), 32'd1);
        dbus_en = 1'b0;
        ar_accept("t2i", 32'hBFC0_0004, 4'd0, 3'd2, 4'b1111);
        chk("t2_istall_c", 32'(ibus_stall), 32'd1);
        r_return("t2i", 32'h2408_000A, 4'd0);
        chk("t2_istall_low", 32'(ibus_stall), 32'd0);
        chk("t2_irdata",     ibus_rdata, 32'h2408_000A);
        chk("t2_drdata_hold", dbus_rdata, 32'h1122_3344);
        ibus_en = 1'b0;
        tick();

        // T3: uncached partial write, W accepted before AW
        dbus_en = 1'b1; dbus_wen = 4'b0011; dbus_wdata = 32'hDEAD_BEEF;
        dbus_addr = 32'h0000_2000; dbus_size = 2'd2; no_dcache = 1'b1;
        tick();
        chk("t3_awvalid", 32'(axi.awvalid), 32'd1);
        chk("t3_wvalid",  32'(axi.wvalid), 32'd1);
        chk("t3_awaddr",  axi.awaddr, 32'h0000_2000);
        chk("t3_awcache", 32'(axi.awcache), 32'd0);
        chk("t3_awsize",  32'(axi.awsize), 32'd2);
        chk("t3_awlen",   32'(axi.awlen), 32'd0);
        chk("t3_awid",    32'(axi.awid), 32'd1);
        chk("t3_wid",     32'(axi.wid), 32'd1);
        chk("t3_wstrb",   32'(axi.wstrb), 32'h3);
        chk("t3_wdata",   axi.wdata, 32'hDEAD_BEEF);
        chk("t3_wlast",   32'(axi.wlast), 32'd1);
        axi.wready = 1'b1;
        tick();
        axi.wready = 1'b0;
        chk("t3_wvalid_off", 32'(axi.wvalid), 32'd0);
        chk("t3_aw_hold",    32'(axi.awvalid), 32'd1);
        chk("t3_stall_wa",   32'(dbus_stall), 32'd1);
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        chk("t3_awvalid_off", 32'(axi.awvalid), 32'd0);
        chk("t3_bready",      32'(axi.bready), 32'd1);
`ifdef SBUS_AXI_POSTED_WR_EN
        chk("t3_stall_posted", 32'(dbus_stall), 32'd0);
        // CPU moves on to a new read while the B response is still outstanding
        dbus_wen = 4'b0000; dbus_addr = 32'h0000_3000; dbus_size = 2'd2; no_dcache = 1'b0;
`else
        chk("t3_stall_preb", 32'(dbus_stall), 32'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_bwait_bready", 32'(axi.bready), 32'd1);
            chk("t3_bwait_ar",     32'(axi.arvalid), 32'd0);
            chk("t3_bwait_stall",  32'(dbus_stall), 32'd1);
        end
        axi.bvalid = 1'b1; axi.bid = 4'd1;
        tick();
        axi.bvalid = 1'b0;
        chk("t3_bready_off", 32'(axi.bready), 32'd0);
`ifdef SBUS_AXI_POSTED_WR_EN
        chk("t3_next_stall", 32'(dbus_stall), 32'd1);
        chk("t3_next_ar_no", 32'(axi.arvalid), 32'd0);
        ar_accept("t3n", 32'h0000_3000, 4'd1, 3'd2, 4'b1111);
        r_return("t3n", 32'h55AA_55AA, 4'd1);
        chk("t3n_stall_low", 32'(dbus_stall), 32'd0);
        chk("t3n_rdata",     dbus_rdata, 32'h55AA_55AA);
`else
        chk("t3_stall_low", 32'(dbus_stall), 32'd0);
`endif
        dbus_en = 1'b0; dbus_wen = 4'b0000; no_dcache = 1'b0;
        tick();

        // T4: reset asserted mid-read, then a clean fetch
        ibus_en = 1'b1; ibus_addr = 32'h8000_0000;
        tick();
        ar_accept("t4", 32'h8000_0000, 4'd0, 3'd2, 4'b1111);
        chk("t4_in_rdr", 32'(axi.rready), 32'd1);
        rst = 1'b0;
        #1;
        chk("t4_rst_ar",     32'(axi.arvalid), 32'd0);
        chk("t4_rst_rready", 32'(axi.rready), 32'd0);
        chk("t4_rst_irdata", ibus_rdata, 32'h0);
        chk("t4_rst_drdata", dbus_rdata, 32'h0);
        ibus_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t4_idle_ar", 32'(axi.arvalid), 32'd0);
        ibus_en = 1'b1; ibus_addr = 32'h8000_0010;
        tick();
        ar_accept("t4f", 32'h8000_0010, 4'd0, 3'd2, 4'b1111);
        r_return("t4f", 32'h1234_5678, 4'd0);
        chk("t4f_stall_low", 32'(ibus_stall), 32'd0);
        chk("t4f_rdata",     ibus_rdata, 32'h1234_5678);
        ibus_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sbus_axi_bridge.md
Name: sbus_axi_bridge

Overview:
- Sits directly downstream of the core's physical ibus/dbus sbus master ports and the MMU's no_dcache flag.
- Merges both single-word sbus requests onto one AXI3 master port toward the memory/interconnect.
- Arbitrates between the two buses, sequences AR/R and AW/W/B handshakes, and holds each bus stalled until its transfer completes.

Parameters:
- ID_I, 4'd0, AXI ID used for instruction fetches.
- ID_D, 4'd1, AXI ID used for data accesses.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- ibus_en  in  1  ifetch request; held high until the cycle stall is low.
- ibus_addr  in  32  physical fetch address, word aligned.
- ibus_rdata  out  32  fetched word; valid in the cycle ibus_stall is low with ibus_en high.
- ibus_stall  out  1  high while an ibus request is pending.
- dbus_en  in  1  data request; held high until stall is low.
- dbus_wen  in  4  byte write strobes; 0 means read.
- dbus_size  in  2  log2 bytes (0/1/2) for reads.
- dbus_addr  in  32  physical data address.
- dbus_wdata  in  32  write data.
- dbus_rdata  out  32  read word; same timing as ibus_rdata.
- dbus_stall  out  1  high while a dbus request is pending.
- no_dcache  in  1  current dbus access is uncached.
- arid,araddr,arlen,arsize,arburst,arcache,arvalid  out  4,32,4,3,2,4,1  AXI AR channel.
- arready  in  1.
- rid,rdata,rresp,rlast,rvalid  in  4,32,2,1,1  AXI R channel.
- rready  out  1.
- awid,awaddr,awlen,awsize,awburst,awcache,awvalid  out  4,32,4,3,2,4,1  AXI AW channel.
- awready  in  1.
- wid,wdata,wstrb,wlast,wvalid  out  4,32,4,1,1  AXI W channel.
- wready  in  1.
- bid,bresp,bvalid  in  4,2,1  AXI B channel.
- bready  out  1.

Behaviour:
- Reset (rst low, async): state IDLE.
  - All valid/ready outputs 0; rdata registers 0.
  - Stalls follow combinational rule below.
  - Reset mid-transaction abandons it; no AXI completion is owed.
- Stall rule: x_stall = x_en & ~x_done. x_done is a one-cycle registered pulse set on capture of the response for bus x.
  - A request seen with done high completes; next cycle done is 0.
- FSM states: IDLE, RD_A, RD_R, WR_A, WR_B, DONE.
- IDLE arbitration, dbus wins over ibus (the pipeline waits on memory before refetch):
  - dbus_en & wen!=0 -> WR_A.
  - dbus_en & wen==0 -> RD_A.
  - else ibus_en -> RD_A.
  - Owner bit and request fields are latched on leaving IDLE; inputs are ignored thereafter.
- RD_A: arvalid=1. Fields:
  - arlen=0, arburst=INCR.
  - arsize = 2 for ibus, dbus_size for dbus.
  - arid = ID_I or ID_D.
  - arcache = 4'b0000 if owner is dbus and no_dcache latched high; else 4'b1111.
  - araddr unchanged.
  - On arready go to RD_R.
- RD_R: rready=1. On rvalid & rlast, capture rdata into owner's rdata reg, pulse owner done, go to DONE. rresp is ignored.
- WR_A: awvalid and wvalid raised together, each dropped independently when its ready is seen (AW/W may complete in either order or the same cycle).
  - Fields: awlen=0, wlast=1, wstrb=dbus_wen, awsize=2, awcache as for reads.
  - When both are accepted, go to WR_B.
- WR_B: bready=1. On bvalid, pulse dbus done, go to DONE. bresp is ignored.
- DONE: one cycle, clears done, returns to IDLE. Any bus transfer takes at least 4 cycles.
- Each rdata register holds its value until overwritten by the next read for that bus.

Optional Feature:
- SBUS_AXI_POSTED_WR_EN defined: dbus done pulses in WR_A once both AW and W are accepted. The FSM still waits in WR_B for bvalid before accepting a new request, so write-after-write order is preserved.
- Undefined: done only after B, as described above.

Decomposition:
- Shared package:
  - FSM state enum.
  - AXI burst/cache constants: INCR=2'b01, CACHE_UC=4'b0000, CACHE_WB=4'b1111.
  - ID defaults.
- No sub-module; a single FSM module.

Test Plan:
- ibus_en, addr 0xBFC00000; arready after 2 cycles; rdata 0x3C080001 -> araddr 0xBFC00000, arid 0, arcache 1111; ibus_stall low exactly one cycle with ibus_rdata=0x3C080001.
- ibus and dbus read (0x00001004, size 0) raised same cycle -> dbus AR first with arsize 0, then ibus AR; ibus stall held throughout.
- dbus write wen 0011, wdata 0xDEADBEEF, no_dcache=1; wready before awready -> wstrb 0011, awcache 0000, done only after bvalid; stall drops after B.
- POSTED_WR_EN defined, same write, bvalid delayed 5 cycles -> dbus_stall low the cycle after both handshakes; next request is not issued until B.
- rst pulled low while in RD_R -> arvalid/rready 0 immediately; after release, state IDLE and a fresh ibus fetch completes normally.
